// File: rtl/drip_valve_controller.sv
// Drip valve sequencer: enforces minimum on-time, maximum on-time with latched timeout fault,
// dry-tank interlock abort and a mandatory closed hold-off after every drip event.
module drip_valve_controller #(
    parameter int unsigned MIN_ON_CYCLES  = 8,
    parameter int unsigned MIN_OFF_CYCLES = 4,
    parameter int unsigned MAX_ON_CYCLES  = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       drip_state_i,
    input  logic       low_level_indicator_i,
    input  logic       fault_clear_i,
    output logic       valve_o,
    output logic       timeout_o,
    output logic       dry_abort_o,
    output logic [7:0] drip_count_o
);

    if (MIN_ON_CYCLES < 1 || MIN_OFF_CYCLES < 1 || MAX_ON_CYCLES <= MIN_ON_CYCLES ||
        longint'(MAX_ON_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_params
        $error("drip_valve_controller: illegal parameter set");
    end

    // Terminal counter values; the counter holds cycles already spent in the current state.
    localparam logic [CNT_W-1:0] MinOnLast  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] MinOffLast = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] MaxOnLast  = CNT_W'(MAX_ON_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StHoldOff,
        StFault
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            valve_o      <= 1'b0;
            timeout_o    <= 1'b0;
            dry_abort_o  <= 1'b0;
            drip_count_o <= 8'd0;
        end else begin
            dry_abort_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (drip_state_i && !low_level_indicator_i) begin
                        state_q <= StOn;
                        cnt_q   <= '0;
                        valve_o <= 1'b1;
                    end
                end
                StOn: begin
                    if (low_level_indicator_i) begin
                        state_q      <= StHoldOff;
                        cnt_q        <= '0;
                        valve_o      <= 1'b0;
                        dry_abort_o  <= 1'b1;
                        drip_count_o <= drip_count_o + 8'd1;
                    end else if (drip_state_i && cnt_q == MaxOnLast) begin
                        state_q      <= StFault;
                        cnt_q        <= '0;
                        valve_o      <= 1'b0;
                        timeout_o    <= 1'b1;
                        drip_count_o <= drip_count_o + 8'd1;
                    end else if (!drip_state_i && cnt_q >= MinOnLast) begin
                        state_q      <= StHoldOff;
                        cnt_q        <= '0;
                        valve_o      <= 1'b0;
                        drip_count_o <= drip_count_o + 8'd1;
                    end else begin
                        // Bounded by MaxOnLast, so this never wraps.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHoldOff: begin
                    if (cnt_q == MinOffLast) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFault: begin
                    if (fault_clear_i) begin
                        state_q   <= StHoldOff;
                        cnt_q     <= '0;
                        timeout_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    valve_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/drip_valve_controller.md
DRIP_VALVE_CONTROLLER -- requirements
Module: drip_valve_controller

Interface
REQ-001 SHALL have parameter MIN_ON_CYCLES, default 8: minimum consecutive valve-open cycles per drip event.
REQ-002 SHALL have parameter MIN_OFF_CYCLES, default 4: mandatory valve-closed hold-off after each event.
REQ-003 SHALL have parameter MAX_ON_CYCLES, default 64: valve-open cycle limit before timeout fault.
REQ-004 SHALL have parameter CNT_W, default 8: internal cycle counter width.
REQ-005 SHALL reject at elaboration any parameter set outside: MIN_ON_CYCLES>=1, MIN_OFF_CYCLES>=1, MAX_ON_CYCLES>MIN_ON_CYCLES, MAX_ON_CYCLES<=2^CNT_W-1.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port drip_state_i, input, 1 bit: drip request from the drip trigger logic.
REQ-009 SHALL have port low_level_indicator_i, input, 1 bit: 1 = tank below low level (dry interlock).
REQ-010 SHALL have port fault_clear_i, input, 1 bit: operator acknowledge of timeout fault.
REQ-011 SHALL have port valve_o, output, 1 bit: drip valve drive, 1 = open.
REQ-012 SHALL have port timeout_o, output, 1 bit: level, 1 while in FAULT.
REQ-013 SHALL have port dry_abort_o, output, 1 bit: one-cycle pulse on a dry-interlock abort.
REQ-014 SHALL have port drip_count_o, output, 8 bits: number of completed drip events.

Function
REQ-015 SHALL implement FSM states IDLE, ON, HOLD_OFF, FAULT; all outputs registered.
REQ-016 SHALL drive valve_o=1 only in ON; 0 in all other states.
REQ-017 IDLE: on an edge sampling drip_state_i=1 and low_level_indicator_i=0, SHALL go to ON with counter cleared; valve_o=1 in the following cycle (latency 1).
REQ-018 IDLE: drip_state_i=1 with low_level_indicator_i=1 SHALL leave the FSM in IDLE; no dry_abort_o pulse.
REQ-019 ON: counter SHALL increment on every edge; value = ON cycles already elapsed.
REQ-020 ON priority 1: low_level_indicator_i=1 SHALL go to HOLD_OFF on that edge, overriding MIN_ON_CYCLES, and pulse dry_abort_o for exactly one cycle.
REQ-021 ON priority 2: at counter==MAX_ON_CYCLES-1 with drip_state_i=1, SHALL go to FAULT.
REQ-022 ON priority 3: drip_state_i=0 with counter>=MIN_ON_CYCLES-1 SHALL go to HOLD_OFF; drip_state_i=0 earlier SHALL stay in ON (minimum on-time).
REQ-023 Result: valve_o open for max(MIN_ON_CYCLES, request length) cycles, capped at MAX_ON_CYCLES, unless dry-aborted.
REQ-024 Every ON exit (release, dry abort, timeout) SHALL increment drip_count_o by 1; 255 SHALL wrap to 0.
REQ-025 HOLD_OFF: counter cleared on entry; SHALL return to IDLE after exactly MIN_OFF_CYCLES cycles; drip_state_i ignored.
REQ-026 FAULT: timeout_o=1, valve_o=0; drip_state_i ignored; fault_clear_i=1 SHALL go to HOLD_OFF and drop timeout_o next cycle.
REQ-027 fault_clear_i outside FAULT SHALL have no effect.
REQ-028 Counter SHALL never wrap (bounded by REQ-005).

Reset
REQ-029 reset_i=1 SHALL, at the next edge, force IDLE, valve_o=0, timeout_o=0, dry_abort_o=0, drip_count_o=0, counter=0, overriding all other inputs in any state, including mid-ON and FAULT.
REQ-030 After reset release, the first request SHALL need no hold-off.

Verification (defaults)
REQ-031 Reset for 2 cycles, drip_state_i=1 -> all outputs 0 during reset; valve_o=1 one cycle after first sampled non-reset edge.
REQ-032 drip_state_i high 3 cycles then low -> valve_o high exactly 8 cycles, low at least 4 cycles before reopening; drip_count_o=1.
REQ-033 drip_state_i high 20 cycles -> valve_o high exactly 20 cycles, delayed 1 cycle; drip_count_o=1.
REQ-034 drip_state_i held 100 cycles -> valve_o high 64 cycles, then timeout_o=1 and valve_o=0 until fault_clear_i; then 4 hold-off cycles, then reopens on request.
REQ-035 low_level_indicator_i=1 on third ON cycle -> valve_o=0 next cycle, dry_abort_o high exactly 1 cycle, drip_count_o increments.
REQ-036 reset_i pulsed at ON cycle 5 with drip_count_o=3 -> valve_o=0 and drip_count_o=0 after that edge.
